// File: rtl/rca_byte_sequencer.sv
// rca_byte_sequencer: feeds an external 8-bit ripple-carry adder one byte
// slice per clock and assembles the wide sum. Optional macro: RCA_SEQ_SUB_EN.
module rca_byte_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] in_a,
    input  logic [8*NBYTES-1:0] in_b,
    input  logic                in_cin,
    input  logic                in_sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_sum,
    output logic                out_cout,
    output logic                out_ovf,
    output logic [7:0]          add_a,
    output logic [7:0]          add_b,
    output logic                add_cin,
    input  logic [7:0]          add_sum,
    input  logic                add_cout
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

`ifdef RCA_SEQ_SUB_EN
    localparam logic SUB_EN = 1'b1;
`else
    localparam logic SUB_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    // Subtraction inverts B and forces the initial carry to 1.
    logic            sub_w;
    logic [W-1:0]    beff_w;
    logic            c0_w;

    assign sub_w  = in_sub & SUB_EN;
    assign beff_w = in_b ^ {W{sub_w}};
    assign c0_w   = sub_w ? 1'b1 : in_cin;

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic, slice selection and handshake outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        in_ready  = ~rst && (state_q == IDLE);
        out_valid = ~rst && (state_q == DONE);
        add_a     = 8'h00;
        add_b     = 8'h00;
        add_cin   = 1'b0;

        if (~rst && (state_q == RUN)) begin
            add_cin = carry_q;
            for (int i = 0; i < NBYTES; i++) begin
                if (idx_q == IW'(i)) begin
                    add_a = a_q[8*i +: 8];
                    add_b = b_q[8*i +: 8];
                end
            end
        end

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = beff_w;
                    carry_d = c0_w;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx_q == IW'(i)) begin
                        sum_d[8*i +: 8] = add_sum;
                    end
                end
                carry_d = add_cout;
                if (idx_q == LAST) begin
                    cout_d  = add_cout;
                    ovf_d   = a_q[W-1] ^ b_q[W-1] ^ add_sum[7] ^ add_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rca_byte_sequencer.sv
// tb_rca_byte_sequencer: directed vectors for the byte-serial adder
// controller, with a behavioural 8-bit adder on the add_* ports.
module tb_rca_byte_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_sum;
    logic        add_cout;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    logic cins [0:7];

    always #5 clk = ~clk;

    // External combinational adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

    rca_byte_sequencer #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair and wait (bounded) for out_valid.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic sub);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (lat < 8) cins[lat] = add_cin;
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_sum", {32'd0, out_sum}, 64'd0);
        chk("rst_add_a", {56'd0, add_a}, 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // Byte carry
        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        chk("bc_latency", 64'(lat), 64'd4);
        chk("bc_sum", {32'd0, out_sum}, 64'h0000_0100);
        chk("bc_cout", {63'd0, out_cout}, 64'd0);
        chk("bc_ovf", {63'd0, out_ovf}, 64'd0);
        drain();
        chk("bc_idle_valid", {63'd0, out_valid}, 64'd0);
        chk("bc_idle_ready", {63'd0, in_ready}, 64'd1);

        // Full ripple
        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        chk("fr_sum", {32'd0, out_sum}, 64'h0);
        chk("fr_cout", {63'd0, out_cout}, 64'd1);
        chk("fr_ovf", {63'd0, out_ovf}, 64'd0);
        chk("fr_cin0", {63'd0, cins[0]}, 64'd0);
        chk("fr_cin1", {63'd0, cins[1]}, 64'd1);
        chk("fr_cin2", {63'd0, cins[2]}, 64'd1);
        chk("fr_cin3", {63'd0, cins[3]}, 64'd1);
        drain();

        // Signed overflow
        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        chk("ov_sum", {32'd0, out_sum}, 64'h8000_0000);
        chk("ov_cout", {63'd0, out_cout}, 64'd0);
        chk("ov_ovf", {63'd0, out_ovf}, 64'd1);
        drain();

        // Backpressure with a second request pending
        start_op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        in_a     = 32'h0000_0010;
        in_b     = 32'h0000_0020;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_sum", {32'd0, out_sum}, 64'd3);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
        chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
        start_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        chk("bp_second_lat", 64'(lat), 64'd4);
        chk("bp_second_sum", {32'd0, out_sum}, 64'h30);
        drain();

        // Reset during RUN
        in_a     = 32'h1234_5678;
        in_b     = 32'h0000_0001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("mr_rst_add_a", {56'd0, add_a}, 64'd0);
        chk("mr_rst_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mr_add_a", {56'd0, add_a}, 64'd0);
        chk("mr_add_b", {56'd0, add_b}, 64'd0);
        chk("mr_add_cin", {63'd0, add_cin}, 64'd0);
        chk("mr_in_ready", {63'd0, in_ready}, 64'd1);
        start_op(32'd3, 32'd4, 1'b0, 1'b0);
        chk("mr_after_sum", {32'd0, out_sum}, 64'd7);
        drain();

        // Subtract request
        start_op(32'd5, 32'd7, 1'b0, 1'b1);
`ifdef RCA_SEQ_SUB_EN
        chk("sub_sum", {32'd0, out_sum}, 64'hFFFF_FFFE);
        chk("sub_cout", {63'd0, out_cout}, 64'd0);
        chk("sub_ovf", {63'd0, out_ovf}, 64'd0);
`else
        chk("sub_sum", {32'd0, out_sum}, 64'h0000_000C);
        chk("sub_cout", {63'd0, out_cout}, 64'd0);
        chk("sub_ovf", {63'd0, out_ovf}, 64'd0);
`endif
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
